// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle LEGv8 control unit (Moore FSM).
//
// Sequences FETCH / DECODE / execute / writeback for LDUR, STUR, CBZ,
// ADD, SUB, AND, ORR and MOVZ over a datapath that shares one memory and
// one ALU. Memory accesses use a ready handshake guarded by a wait
// counter. Undecodable opcodes and stalled accesses raise a one-cycle
// exception.
//
// Parameters
//   MAX_WAIT      cycles an access may wait for mem_ready (0 = no limit)
//   SUPPORT_MOVZ  1 executes MOVZ, 0 treats it as an invalid opcode
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   Op[10:0]           Instr[31:21] from the IR
//   zero               ALU zero flag
//   mem_ready          memory completes the current access this cycle
//   Reg2Loc..mov       single-bit datapath controls
//   ALUSrcB[1:0]       00 reg, 01 const 4, 10 sign-ext imm, 11 branch offset
//   ALUOp[1:0]         00 add, 01 pass-B, 10 R-type funct, 11 MOVZ
//   pc_en              PCWrite | (PCWriteCond & zero)
//   instr_done         pulse in the last cycle of each instruction
//   exc, exc_code      exception pulse and cause (01 opcode, 10 timeout)
//   state[3:0]         current state (debug)
module multicycle_ctrl #(
    parameter int MAX_WAIT     = 15,
    parameter bit SUPPORT_MOVZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        Reg2Loc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        PCSrc,
    output logic        mov,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        pc_en,
    output logic        instr_done,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic [3:0]  state
);

    // A zero-width counter is not legal, so MAX_WAIT=0 keeps one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_MAX = '1;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_OPC   = 2'b01;
    localparam logic [1:0] EC_TMOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_EXC    = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [1:0]    exc_code_q, exc_code_d;
    logic          movz_q, movz_d;   // instruction in flight is MOVZ

    logic wait_state;
    logic timeout;
    logic pc_write, pc_write_cond;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
    // mem_ready arriving on the limit cycle still counts as success.
    assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_LIM) && !mem_ready;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        movz_d     = movz_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_TMOUT;
                end
            end
            S_DECODE: begin
                movz_d = 1'b0;
                casez (Op)
                    11'b11111000010,
                    11'b11111000000: state_d = S_MEMADR;
                    11'b10001011000,
                    11'b11001011000,
                    11'b10001010000,
                    11'b10101010000: state_d = S_EXEC;
                    11'b110100101??: begin
                        if (SUPPORT_MOVZ) begin
                            state_d = S_EXEC;
                            movz_d  = 1'b1;
                        end else begin
                            state_d    = S_EXC;
                            exc_code_d = EC_OPC;
                        end
                    end
                    11'b10110100???: state_d = S_BRANCH;
                    default: begin
                        state_d    = S_EXC;
                        exc_code_d = EC_OPC;
                    end
                endcase
            end
            S_MEMADR: state_d = (Op == OP_STUR) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_TMOUT;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_TMOUT;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_EXC: begin
                state_d    = S_FETCH;
                exc_code_d = EC_NONE;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Wait counter: restarts whenever the state changes, so every entry
    // into a wait state begins at zero. Saturates for the unlimited case.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_state && !mem_ready && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_q     <= '0;
            exc_code_q <= EC_NONE;
            movz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            exc_code_q <= exc_code_d;
            movz_q     <= movz_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore on state_q; handshake-qualified strobes use inputs)
    // ------------------------------------------------------------------
    always_comb begin
        Reg2Loc       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        ALUSrcA       = 1'b0;
        PCSrc         = 1'b0;
        mov           = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        instr_done    = 1'b0;
        exc           = 1'b0;
        exc_code      = EC_NONE;
        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Reg2Loc = (Op == OP_STUR);
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                Reg2Loc    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = movz_q ? 2'b11 : 2'b10;
                mov     = movz_q;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                mov        = movz_q;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                Reg2Loc       = 1'b1;
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                PCSrc         = 1'b1;
                instr_done    = 1'b1;
            end
            S_EXC: begin
                exc      = 1'b1;
                exc_code = exc_code_q;
            end
            default: ;
        endcase
        pc_en = pc_write | (pc_write_cond & zero);
        // Reset may land mid-instruction: suppress every side effect.
        if (reset) begin
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            IRWrite    = 1'b0;
            pc_en      = 1'b0;
            instr_done = 1'b0;
            exc        = 1'b0;
            exc_code   = EC_NONE;
        end
    end

    assign state = state_q;

    // Op[4:0]-style fields are decoded by casez above; OP_LDUR kept for
    // readability of the memory path.
    logic unused_ok;
    assign unused_ok = (OP_LDUR == 11'b0);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                           MW = 4'd5, EX = 4'd6, AW = 4'd7, BR = 4'd8, XC = 4'd9;
    localparam logic [10:0] ADD  = 11'b10001011000, SUB = 11'b11001011000,
                            ANDI = 11'b10001010000, ORR = 11'b10101010000,
                            LDUR = 11'b11111000010, STUR = 11'b11111000000,
                            CBZ  = 11'b10110100101, MOVZ = 11'b11010010100,
                            BAD  = 11'b00000000000;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [10:0] Op = BAD;
    always #5 clk = ~clk;

    logic r2l, m2r, rw, mrd, mwr, iord, irw, asa, pcs, mv, pce, dn, ex;
    logic [1:0] asb, aop, ec;
    logic [3:0] st;
    logic r2l2, m2r2, rw2, mrd2, mwr2, iord2, irw2, asa2, pcs2, mv2, pce2, dn2, ex2;
    logic [1:0] asb2, aop2, ec2;
    logic [3:0] st2;

    multicycle_ctrl #(.MAX_WAIT(3), .SUPPORT_MOVZ(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .Reg2Loc(r2l), .MemtoReg(m2r), .RegWrite(rw), .MemRead(mrd), .MemWrite(mwr),
        .IorD(iord), .IRWrite(irw), .ALUSrcA(asa), .PCSrc(pcs), .mov(mv),
        .ALUSrcB(asb), .ALUOp(aop), .pc_en(pce), .instr_done(dn), .exc(ex),
        .exc_code(ec), .state(st));

    multicycle_ctrl #(.MAX_WAIT(15), .SUPPORT_MOVZ(1'b0)) dut2 (
        .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .Reg2Loc(r2l2), .MemtoReg(m2r2), .RegWrite(rw2), .MemRead(mrd2), .MemWrite(mwr2),
        .IorD(iord2), .IRWrite(irw2), .ALUSrcA(asa2), .PCSrc(pcs2), .mov(mv2),
        .ALUSrcB(asb2), .ALUOp(aop2), .pc_en(pce2), .instr_done(dn2), .exc(ex2),
        .exc_code(ec2), .state(st2));

    logic [22:0] obs, obs2;
    assign obs  = {st, r2l, m2r, rw, mrd, mwr, iord, irw, asa, pcs, mv,
                   asb, aop, pce, dn, ex, ec};
    assign obs2 = {st2, r2l2, m2r2, rw2, mrd2, mwr2, iord2, irw2, asa2, pcs2, mv2,
                   asb2, aop2, pce2, dn2, ex2, ec2};

    typedef struct packed {
        logic [3:0]  st;
        logic        mr, z, mv, stur, rst;
        logic [1:0]  code;
        logic [10:0] op;
    } step_t;

    logic [22:0] sb[$];
    logic [22:0] sb2[$];
    int checks = 0, failures = 0;

    // Reference output table: what each state must drive, from the
    // control-signal description of the block.
    function automatic logic [22:0] exp_vec(input logic [3:0] s, input logic r,
                                            input logic z, input logic m,
                                            input logic su, input logic rs,
                                            input logic [1:0] cd);
        logic a_r2l, a_m2r, a_rw, a_mrd, a_mwr, a_iord, a_irw, a_asa, a_pcs, a_mv;
        logic a_pce, a_dn, a_ex;
        logic [1:0] a_asb, a_aop, a_ec;
        {a_r2l, a_m2r, a_rw, a_mrd, a_mwr, a_iord, a_irw, a_asa, a_pcs, a_mv} = '0;
        {a_pce, a_dn, a_ex, a_asb, a_aop, a_ec} = '0;
        case (s)
            FE: begin a_mrd = 1; a_asb = 2'b01; a_irw = r; a_pce = r; end
            DE: a_asb = 2'b11;
            MA: begin a_asa = 1; a_asb = 2'b10; a_r2l = su; end
            MR: begin a_iord = 1; a_mrd = 1; end
            MB: begin a_rw = 1; a_m2r = 1; a_dn = 1; end
            MW: begin a_iord = 1; a_mwr = 1; a_r2l = 1; a_dn = r; end
            EX: begin a_asa = 1; a_aop = m ? 2'b11 : 2'b10; a_mv = m; end
            AW: begin a_rw = 1; a_mv = m; a_dn = 1; end
            BR: begin a_r2l = 1; a_asa = 1; a_aop = 2'b01; a_pcs = 1; a_pce = z; a_dn = 1; end
            XC: begin a_ex = 1; a_ec = cd; end
            default: ;
        endcase
        if (rs) {a_rw, a_mwr, a_mrd, a_irw, a_pce, a_dn, a_ex, a_ec} = '0;
        return {s, a_r2l, a_m2r, a_rw, a_mrd, a_mwr, a_iord, a_irw, a_asa, a_pcs, a_mv,
                a_asb, a_aop, a_pce, a_dn, a_ex, a_ec};
    endfunction

    function automatic step_t mk(input logic [3:0] s, input logic r, input logic [10:0] o,
                                 input logic z, input logic m, input logic su,
                                 input logic [1:0] cd, input logic rs);
        step_t t;
        t.st = s; t.mr = r; t.op = o; t.z = z; t.mv = m; t.stur = su; t.code = cd; t.rst = rs;
        return t;
    endfunction

    // Drives one cycle of inputs and records its expected outputs.
    task automatic apply(input step_t t);
        Op = t.op; mem_ready = t.mr; zero = t.z; reset = t.rst;
        sb.push_back(exp_vec(t.st, t.mr, t.z, t.mv, t.stur, t.rst, t.code));
    endtask

    task automatic test_reset;
        step_t s[$];
        logic [22:0] e;
        repeat (3) s.push_back(mk(FE, 1, BAD, 0, 0, 0, 2'b00, 1));
        s.push_back(mk(FE, 0, BAD, 0, 0, 0, 2'b00, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL reset[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype;
        step_t s[$];
        logic [22:0] e;
        logic [10:0] ops[4];
        ops = '{ADD, SUB, ANDI, ORR};
        foreach (ops[k]) begin
            s.push_back(mk(FE, 1, ops[k], 0, 0, 0, 2'b00, 0));
            s.push_back(mk(DE, 1, ops[k], 0, 0, 0, 2'b00, 0));
            s.push_back(mk(EX, 1, ops[k], 0, 0, 0, 2'b00, 0));
            s.push_back(mk(AW, 1, ops[k], 0, 0, 0, 2'b00, 0));
        end
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL rtype[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    // LDUR with two stall cycles; Op is scrambled during MEMRD and must
    // not matter.
    task automatic test_ldur_wait;
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(FE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MA, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MR, 0, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MR, 0, BAD,  0, 0, 0, 2'b00, 0));
        s.push_back(mk(MR, 1, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MB, 1, BAD,  0, 0, 0, 2'b00, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL ldur[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    // STUR with immediate ready, then STUR whose ready lands exactly on
    // the wait limit (counts as success).
    task automatic test_stur;
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(FE, 1, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, STUR, 0, 0, 1, 2'b00, 0));
        s.push_back(mk(MA, 1, STUR, 0, 0, 1, 2'b00, 0));
        s.push_back(mk(MW, 1, STUR, 0, 0, 1, 2'b00, 0));
        s.push_back(mk(FE, 1, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MA, 1, STUR, 0, 0, 1, 2'b00, 0));
        repeat (3) s.push_back(mk(MW, 0, STUR, 0, 0, 1, 2'b00, 0));
        s.push_back(mk(MW, 1, STUR, 0, 0, 1, 2'b00, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL stur[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cbz;
        step_t s[$];
        logic [22:0] e;
        for (int z = 1; z >= 0; z--) begin
            s.push_back(mk(FE, 1, CBZ, z[0], 0, 0, 2'b00, 0));
            s.push_back(mk(DE, 1, CBZ, z[0], 0, 0, 2'b00, 0));
            s.push_back(mk(BR, 1, CBZ, z[0], 0, 0, 2'b00, 0));
        end
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL cbz[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_invalid;
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(FE, 1, BAD, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, BAD, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(XC, 1, ADD, 0, 0, 0, 2'b01, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL invalid[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    // MOVZ on both builds: executes on dut, invalid opcode on dut2.
    task automatic test_movz;
        step_t s[$];
        step_t s2[$];
        logic [22:0] e, e2;
        s.push_back(mk(FE, 1, MOVZ, 0, 0, 0, 2'b00, 0));  s2.push_back(mk(FE, 1, MOVZ, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, MOVZ, 0, 0, 0, 2'b00, 0));  s2.push_back(mk(DE, 1, MOVZ, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(EX, 0, MOVZ, 0, 1, 0, 2'b00, 0));  s2.push_back(mk(XC, 0, MOVZ, 0, 0, 0, 2'b01, 0));
        s.push_back(mk(AW, 0, MOVZ, 0, 1, 0, 2'b00, 0));  s2.push_back(mk(FE, 0, MOVZ, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(FE, 0, MOVZ, 0, 0, 0, 2'b00, 1));  s2.push_back(mk(FE, 0, MOVZ, 0, 0, 0, 2'b00, 1));
        foreach (s[i]) begin
            apply(s[i]);
            sb2.push_back(exp_vec(s2[i].st, s2[i].mr, s2[i].z, s2[i].mv, s2[i].stur,
                                  s2[i].rst, s2[i].code));
            @(negedge clk);
            e = sb.pop_front(); e2 = sb2.pop_front(); checks += 2;
            if (obs !== e) begin failures++; $display("FAIL movz[%0d] got=%h want=%h", i, obs, e); end
            if (obs2 !== e2) begin failures++; $display("FAIL movz_off[%0d] got=%h want=%h", i, obs2, e2); end
            @(posedge clk); #1;
        end
    endtask

    // MAX_WAIT=3: STUR stuck in MEMWR, then FETCH stuck as well.
    task automatic test_timeout;
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(FE, 1, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 0, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MA, 0, STUR, 0, 0, 1, 2'b00, 0));
        repeat (4) s.push_back(mk(MW, 0, STUR, 0, 0, 1, 2'b00, 0));
        s.push_back(mk(XC, 0, STUR, 0, 0, 0, 2'b10, 0));
        repeat (4) s.push_back(mk(FE, 0, STUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(XC, 0, STUR, 0, 0, 0, 2'b10, 0));
        s.push_back(mk(FE, 0, STUR, 0, 0, 0, 2'b00, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL timeout[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(FE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MA, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MR, 0, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(MR, 1, LDUR, 0, 0, 0, 2'b00, 1));
        s.push_back(mk(FE, 0, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(FE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        s.push_back(mk(DE, 1, LDUR, 0, 0, 0, 2'b00, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_ldur_wait();
        test_stur();
        test_cbz();
        test_invalid();
        test_movz();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the LEGv8 datapath: a Moore FSM that sequences FETCH/DECODE/execute/writeback steps for LDUR, STUR, CBZ, ADD, SUB, AND, ORR and MOVZ over several cycles. It replaces the single-cycle main decoder when the datapath shares one memory and one ALU across cycles. It adds a ready/timeout handshake to memory, plus invalid-opcode and timeout exceptions.

## Interface
- MAX_WAIT, 15: max cycles a memory access may wait for mem_ready; 0 disables the timeout.
- SUPPORT_MOVZ, 1: 1 executes MOVZ; 0 treats MOVZ as an invalid opcode.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  11  Instr[31:21] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, IorD, IRWrite, ALUSrcA, PCSrc, mov  out  1  datapath controls.
- ALUSrcB  out  2  00 reg, 01 const 4, 10 sign-ext imm, 11 branch offset (shifted).
- ALUOp  out  2  00 add, 01 pass-B/CBZ, 10 R-type funct, 11 MOVZ.
- pc_en  out  1  PC write enable = PCWrite | (PCWriteCond & zero).
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- exc  out  1  one-cycle exception pulse.
- exc_code  out  2  01 invalid opcode, 10 memory timeout; 00 when exc=0.
- state  out  4  current state encoding (debug).

## Operation
- Controls decode from the state register; pc_en, IRWrite and instr_done also use mem_ready/zero. Unlisted outputs are 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. When mem_ready=1, IRWrite=1 and pc_en=1, then go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Op 11111000010 (LDUR) or 11111000000 (STUR) → MEMADR.
  - 10001011000 / 11001011000 / 10001010000 / 10101010000 → EXEC.
  - 110100101?? → EXEC if SUPPORT_MOVZ, else EXC.
  - 10110100??? → BRANCH.
  - Anything else → EXC with code 01.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Reg2Loc=1 if STUR. Goes to MEMRD for LDUR, MEMWR for STUR.
- MEMRD: IorD=1, MemRead=1. On mem_ready → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1, Reg2Loc=1. On mem_ready: instr_done=1 → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUOp=10, or ALUOp=11 with mov=1 for MOVZ. → ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, mov held from EXEC, instr_done=1 → FETCH.
- BRANCH: Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1, instr_done=1 → FETCH.
- EXC: exc=1 with the latched exc_code; no write strobes → FETCH.
- Wait counter:
  - Width $clog2(MAX_WAIT+1).
  - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle in those states while mem_ready=0.
  - If MAX_WAIT>0, count==MAX_WAIT and mem_ready=0: go to EXC with code 10. The access strobes (MemWrite/MemRead) drop on the next cycle.
  - mem_ready in the same cycle as count==MAX_WAIT counts as success.

## Timing
- Reset: state=FETCH, wait counter=0, latched exc_code=00.
  - While reset=1, RegWrite, MemWrite, MemRead, IRWrite, pc_en, instr_done and exc are forced 0.
  - Reset mid-instruction abandons it; the first cycle after reset deasserts is FETCH.
- Latency with mem_ready always 1: LDUR 5 cycles, STUR 4, R-type/MOVZ 4, CBZ 3, invalid 3 (FETCH, DECODE, EXC).
- Each cycle of mem_ready=0 in a wait state adds one cycle.
- MemWrite is high for exactly the cycles spent in MEMWR. Memory commits the store only in the cycle where mem_ready=1.
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states have no effect.
- The CBZ PC update happens on the BRANCH cycle edge iff zero=1.

## Test plan
- Reset held 3 cycles, then released → state=FETCH, no write strobe during reset, MemRead=1 on the first cycle after reset.
- ADD (Op=10001011000), mem_ready=1 → FETCH, DECODE, EXEC (ALUOp=10), ALUWB (RegWrite=1, instr_done=1): 4 cycles, back to FETCH.
- LDUR with mem_ready low for 2 cycles in MEMRD → 7 cycles total; MemtoReg=1 and RegWrite=1 only in MEMWB.
- CBZ with zero=1, then again with zero=0 → pc_en=1 in BRANCH only in the zero=1 case; 3 cycles each.
- Op=00000000000 → EXC on cycle 3 with exc=1, exc_code=01, no RegWrite/MemWrite. With SUPPORT_MOVZ=0, MOVZ gives the same result.
- MAX_WAIT=3, STUR with mem_ready stuck at 0 → MEMWR holds 4 cycles, then EXC (exc_code=10), then FETCH.
